seq_detector_param: RTL and testbench

Parametrised, clocked serial bit-pattern detector with runtime-programmable pattern, pattern length and overlap mode.
- Accepts one bit per cycle under a valid qualifier.
- Pulses a registered match flag whenever the most recent bits equal the programmed pattern.
- Keeps a saturating match counter.
- Serves as the general replacement for the fixed-pattern, unclocked detector FSMs used in the serial-input front ends.

---
 rtl/seq_detector_param.sv | 114 +++++++++++
 tb/tb_seq_detector_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Clocked serial bit-pattern detector with runtime pattern, length and overlap mode.
// Optional match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             armed,
  output logic [LEN_W-1:0] fill,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q;
  logic             hit;
  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;

  // Config strobe has priority over a simultaneous data bit, which is dropped.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    hit      = 1'b0;
    shifted  = {hist_q[PAT_W-2:0], in_bit};
    fill_inc = (fill_q < len_q) ? fill_q + 1'b1 : len_q;
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ((cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W))) ? ARMED : IDLE;
    end else if ((state_q == ARMED) && in_valid) begin
      hist_d = shifted;
      if ((fill_inc == len_q) && (((shifted ^ pat_q) & mask) == '0)) begin
        hit = 1'b1;
      end
      // Non-overlap: zero fill so stale history can never complete a match.
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Clear beats a same-cycle match; count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cnt_clr) begin
      count_q <= '0;
    end else if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

  assign armed = (state_q == ARMED);
  assign fill  = fill_q;
  assign match = match_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed plan steps plus random traffic against a
// queue-based reference model; counter expectations follow SEQDET_COUNT_EN.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             armed;
  logic [LEN_W-1:0] fill;
  logic             match;
  logic [CNT_W-1:0] match_count;

  int errors = 0;
  int checks = 0;

  // Reference model: bits received since the last discard, most recent at the back.
  bit         m_bits[$];
  logic [PAT_W-1:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_armed;
  bit         m_match;
  int         m_count;
  int         match_tally;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .cnt_clr(cnt_clr), .armed(armed), .fill(fill),
    .match(match), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
`ifdef SEQDET_COUNT_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pat = '0; m_len = 0; m_ovl = 0;
    m_armed = 0; m_match = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit we, input logic [PAT_W-1:0] pat, input int len,
                            input bit ovl, input bit v, input bit b, input bit clr);
    bit ok;
    m_match = 0;
    if (we) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_bits.delete();
      m_armed = (len >= 1) && (len <= PAT_W);
    end else if (m_armed && v) begin
      m_bits.push_back(b);
      if (m_bits.size() > m_len) void'(m_bits.pop_front());
      if (m_bits.size() == m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[k] != m_pat[m_len-1-k]) ok = 0;
        if (ok) begin
          m_match = 1;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
    if (clr) m_count = 0;
    else if (m_match && m_count < CNT_MAX) m_count++;
  endtask

  task automatic step(input bit we, input logic [PAT_W-1:0] pat, input int len,
                      input bit ovl, input bit v, input bit b, input bit clr);
    @(negedge clk);
    cfg_we = we; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    in_valid = v; in_bit = b; cnt_clr = clr;
    @(posedge clk);
    model_edge(we, pat, len, ovl, v, b, clr);
    #1;
    if (m_match) match_tally++;
    check("armed", 32'(armed), 32'(m_armed));
    check("fill", 32'(fill), 32'(m_bits.size()));
    check("match", 32'(match), 32'(m_match));
    check("match_count", 32'(match_count), 32'(exp_count()));
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
    step(1, pat, len, ovl, 0, 0, 0);
  endtask

  task automatic send(input bit b);
    step(0, '0, 0, 0, 1, b, 0);
  endtask

  task automatic idle_cycle();
    step(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    cfg_we = 0; in_valid = 0; cnt_clr = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit stream7[7];
    stream7 = '{1, 0, 1, 1, 0, 1, 1};
    model_reset();
    match_tally = 0;
    pulse_reset();

    // Overlap: 1011 on 1,0,1,1,0,1,1 gives two matches.
    configure(4'b1011, 4, 1);
    match_tally = 0;
    foreach (stream7[i]) send(stream7[i]);
    check("ovl_tally", 32'(match_tally), 32'd2);

    // Non-overlap: one match, fill ends at 3.
    configure(4'b1011, 4, 0);
    match_tally = 0;
    foreach (stream7[i]) send(stream7[i]);
    check("novl_tally", 32'(match_tally), 32'd1);
    check("novl_fill", 32'(fill), 32'd3);

    // Invalid length keeps block idle.
    configure(4'b1011, 0, 1);
    match_tally = 0;
    send(1); send(0); send(1); send(1);
    check("idle_tally", 32'(match_tally), 32'd0);

    // Short pattern 11, overlapping.
    configure(4'b0011, 2, 1);
    match_tally = 0;
    send(1); send(1); send(1);
    check("len2_tally", 32'(match_tally), 32'd2);

    // Gaps between bits freeze fill.
    configure(4'b1011, 4, 1);
    match_tally = 0;
    send(1); repeat (3) idle_cycle();
    send(0); repeat (3) idle_cycle();
    send(1); repeat (3) idle_cycle();
    send(1); repeat (3) idle_cycle();
    check("gap_tally", 32'(match_tally), 32'd1);

    // cfg_we with in_valid: bit discarded.
    send(1);
    step(1, 4'b1011, 4, 1, 1, 1, 0);
    check("cfg_vs_bit_fill", 32'(fill), 32'd0);

    // Saturation then clear coincident with a match.
    step(0, '0, 0, 0, 0, 0, 1);
    configure(4'b0011, 2, 1);
    repeat (6) send(1);
    step(0, '0, 0, 0, 1, 1, 1);
    check("clr_with_match", 32'(match_count), 32'd0);

    // Reset mid-stream.
    configure(4'b1011, 4, 1);
    send(1); send(0); send(1);
    pulse_reset();
    match_tally = 0;
    send(1);
    check("post_rst_tally", 32'(match_tally), 32'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        int len;
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (1 << LEN_W) - 1)
                                          : $urandom_range(1, PAT_W);
        step(1, PAT_W'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      end else if (r < 5) begin
        pulse_reset();
      end else begin
        step(0, PAT_W'($urandom), $urandom_range(0, 7), 1'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 30) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
